// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment display reader.
// Optional build macro used by the top: SEG7_ERRCNT_EN.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned VAL_W = 4;
  localparam int unsigned CNT_W = 8;

  localparam logic [SEG_W-1:0] BLANK = 7'h7F;

  // Active-low glyphs for hex digits; element i is the glyph for value i.
  localparam logic [15:0][SEG_W-1:0] SEG_PATTERNS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    SETTLE      = 2'd0,
    HOLD        = 2'd1,
    WAIT_CHANGE = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_pattern_match.sv
// Combinational glyph lookup: segment pattern to hex value, hit and blank flags.
module seg7_pattern_match
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pat,
  output logic [VAL_W-1:0] value,
  output logic             hit,
  output logic             blank
);

  // Glyphs are unique, so at most one entry can match.
  always_comb begin
    value = '0;
    hit   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pat == SEG_PATTERNS[i]) begin
        value = VAL_W'(i);
        hit   = 1'b1;
      end
    end
  end

  assign blank = (pat == BLANK);

endmodule

// File: rtl/seg7_reader.sv
// Debounces a seven-segment bus and delivers each newly displayed hex digit once
// over a valid/ready handshake. Define SEG7_ERRCNT_EN to add the ERR_COUNT port.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [SEG_W-1:0] HEX_IN,
  output logic [VAL_W-1:0] DIGIT,
  output logic             DIGIT_VALID,
  input  logic             DIGIT_READY,
  output logic             PAT_ERR
`ifdef SEG7_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] ERR_COUNT
`endif
);

  localparam logic [CNT_W-1:0] CNT_THRESH = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state, state_n;
  logic [SEG_W-1:0] hex_q, last_pat, last_pat_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [VAL_W-1:0] digit_n;
  logic             valid_n, err_n;

  logic [VAL_W-1:0] match_value;
  logic             match_hit, match_blank;

  seg7_pattern_match u_match (
    .pat   (HEX_IN),
    .value (match_value),
    .hit   (match_hit),
    .blank (match_blank)
  );

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) state <= SETTLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    digit_n    = DIGIT;
    valid_n    = DIGIT_VALID;
    err_n      = 1'b0;
    last_pat_n = last_pat;
    if (HEX_IN != hex_q)     cnt_n = '0;
    else if (cnt != CNT_MAX) cnt_n = cnt + CNT_W'(1);
    else                     cnt_n = cnt;

    unique case (state)
      SETTLE: begin
        // Decide on the edge that completes STABLE_CYCLES identical samples.
        if ((HEX_IN == hex_q) && (cnt >= CNT_THRESH)) begin
          last_pat_n = HEX_IN;
          state_n    = WAIT_CHANGE;
          if (match_hit) begin
            digit_n = match_value;
            valid_n = 1'b1;
            state_n = HOLD;
          end else if (!match_blank) begin
            err_n = 1'b1;
          end
        end
      end
      HOLD: begin
        if (DIGIT_VALID && DIGIT_READY) begin
          valid_n = 1'b0;
          if (HEX_IN == last_pat) begin
            state_n = WAIT_CHANGE;
          end else begin
            state_n = SETTLE;
            cnt_n   = '0;
          end
        end
      end
      WAIT_CHANGE: begin
        if (HEX_IN != last_pat) begin
          state_n = SETTLE;
          cnt_n   = '0;
        end
      end
      default: state_n = SETTLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      hex_q       <= BLANK;
      last_pat    <= BLANK;
      cnt         <= '0;
      DIGIT       <= '0;
      DIGIT_VALID <= 1'b0;
      PAT_ERR     <= 1'b0;
    end else begin
      hex_q       <= HEX_IN;
      last_pat    <= last_pat_n;
      cnt         <= cnt_n;
      DIGIT       <= digit_n;
      DIGIT_VALID <= valid_n;
      PAT_ERR     <= err_n;
    end
  end

`ifdef SEG7_ERRCNT_EN
  // Counts in step with the PAT_ERR pulse, sticking at all-ones.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET)                            ERR_COUNT <= '0;
    else if (err_n && ERR_COUNT != CNT_MAX) ERR_COUNT <= ERR_COUNT + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_seg7_reader.sv
// Directed self-checking bench for seg7_reader (STABLE_CYCLES = 4).
module tb_seg7_reader;

  logic       clk;
  logic       rst;
  logic [6:0] hex;
  logic [3:0] digit;
  logic       valid;
  logic       ready;
  logic       pat_err;
`ifdef SEG7_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int checks = 0;
  int errors = 0;

  seg7_reader #(.STABLE_CYCLES(4)) dut (
    .CLOCK_50    (clk),
    .RESET       (rst),
    .HEX_IN      (hex),
    .DIGIT       (digit),
    .DIGIT_VALID (valid),
    .DIGIT_READY (ready),
    .PAT_ERR     (pat_err)
`ifdef SEG7_ERRCNT_EN
    ,
    .ERR_COUNT   (err_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  int pulses;
  int vcount;
  int episodes;

  initial begin
    rst   = 1'b1;
    hex   = 7'h7F;
    ready = 1'b0;
    #2;
    chk("rst_digit", 32'(digit), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_err", 32'(pat_err), 32'h0);
`ifdef SEG7_ERRCNT_EN
    chk("rst_errcnt", 32'(err_count), 32'h0);
`endif
    step(2);
    rst = 1'b0;
    step(6);

    // Digit 2 with READY held high: valid for exactly one cycle, 4 edges after first sample.
    hex   = 7'h24;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("d2_pre_valid", 32'(valid), 32'h0);
    end
    step(1);
    chk("d2_valid", 32'(valid), 32'h1);
    chk("d2_digit", 32'(digit), 32'h2);
    step(1);
    chk("d2_post_valid", 32'(valid), 32'h0);
    step(3);
    chk("d2_no_repeat", 32'(valid), 32'h0);

    // Toggling 30/19 every 3 cycles never settles.
    for (int p = 0; p < 8; p++) begin
      hex = (p % 2 == 0) ? 7'h30 : 7'h19;
      for (int i = 0; i < 3; i++) begin
        step(1);
        chk("toggle_valid", 32'(valid), 32'h0);
        chk("toggle_err", 32'(pat_err), 32'h0);
      end
    end
    hex = 7'h7F;
    step(10);
    chk("blank_valid", 32'(valid), 32'h0);

    // Digit F held against backpressure; bus change during hold is ignored.
    ready = 1'b0;
    hex   = 7'h0E;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("dF_pre_valid", 32'(valid), 32'h0);
    end
    step(1);
    chk("dF_valid", 32'(valid), 32'h1);
    chk("dF_digit", 32'(digit), 32'hF);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("dF_hold_valid", 32'(valid), 32'h1);
      chk("dF_hold_digit", 32'(digit), 32'hF);
    end
    hex = 7'h00;
    for (int i = 0; i < 2; i++) begin
      step(1);
      chk("dF_hold2_valid", 32'(valid), 32'h1);
      chk("dF_hold2_digit", 32'(digit), 32'hF);
    end
    ready = 1'b1;
    step(1);
    chk("dF_xfer_valid", 32'(valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("d8_pre_valid", 32'(valid), 32'h0);
    end
    step(1);
    chk("d8_valid", 32'(valid), 32'h1);
    chk("d8_digit", 32'(digit), 32'h8);
    step(1);
    chk("d8_post_valid", 32'(valid), 32'h0);

    // Stable invalid glyph 55: one PAT_ERR pulse on the 4th edge, then silence.
    hex    = 7'h55;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("inv_err_timing", 32'(pat_err), (i == 4) ? 32'h1 : 32'h0);
      chk("inv_valid", 32'(valid), 32'h0);
      if (pat_err) pulses++;
    end
    chk("inv_pulses", 32'(pulses), 32'h1);
`ifdef SEG7_ERRCNT_EN
    chk("inv_errcnt", 32'(err_count), 32'h1);
    episodes = 300;
`else
    episodes = 3;
`endif

    // Alternating blank/invalid episodes: each invalid episode flags once.
    pulses = 0;
    for (int e = 0; e < episodes; e++) begin
      hex = 7'h7F;
      for (int i = 0; i < 6; i++) begin
        step(1);
        if (pat_err) pulses++;
      end
      hex = 7'h55;
      for (int i = 0; i < 6; i++) begin
        step(1);
        if (pat_err) pulses++;
      end
    end
    chk("episode_pulses", 32'(pulses), 32'(episodes));
`ifdef SEG7_ERRCNT_EN
    chk("errcnt_sat", 32'(err_count), 32'hFF);
`endif
    hex = 7'h7F;
    step(6);

    // Digit 0 held after transfer is not re-emitted; blank then 0 emits again.
    hex = 7'h40;
    step(4);
    chk("d0_pre_valid", 32'(valid), 32'h0);
    step(1);
    chk("d0_valid", 32'(valid), 32'h1);
    chk("d0_digit", 32'(digit), 32'h0);
    vcount = 0;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (valid) vcount++;
      if (pat_err) pulses++;
    end
    chk("d0_no_reemit", 32'(vcount), 32'h0);
    chk("d0_no_err", 32'(pulses), 32'h0);
    hex = 7'h7F;
    step(6);
    chk("d0_blank_valid", 32'(valid), 32'h0);
    hex = 7'h40;
    step(4);
    chk("d0b_pre_valid", 32'(valid), 32'h0);
    step(1);
    chk("d0b_valid", 32'(valid), 32'h1);
    chk("d0b_digit", 32'(digit), 32'h0);
    step(1);
    chk("d0b_post_valid", 32'(valid), 32'h0);

    // Reset mid-cycle during HOLD clears outputs before the next edge.
    ready = 1'b0;
    hex   = 7'h12;
    step(5);
    chk("d5_valid", 32'(valid), 32'h1);
    chk("d5_digit", 32'(digit), 32'h5);
    step(2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(valid), 32'h0);
    chk("async_rst_digit", 32'(digit), 32'h0);
    chk("async_rst_err", 32'(pat_err), 32'h0);
`ifdef SEG7_ERRCNT_EN
    chk("async_rst_errcnt", 32'(err_count), 32'h0);
`endif
    #1;
    rst = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("post_rst_pre_valid", 32'(valid), 32'h0);
    end
    step(1);
    chk("post_rst_valid", 32'(valid), 32'h1);
    chk("post_rst_digit", 32'(digit), 32'h5);
    step(1);
    chk("post_rst_xfer", 32'(valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, consecutive identical samples needed before a pattern is decoded (legal 2..255).
REQ-002 SHALL have port CLOCK_50  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port HEX_IN  input  7  active-low segment bus; bit0=a ... bit6=g.
REQ-005 SHALL have port DIGIT  output  4  decoded hex value.
REQ-006 SHALL have port DIGIT_VALID  output  1  DIGIT holds an undelivered value.
REQ-007 SHALL have port DIGIT_READY  input  1  consumer accepts DIGIT.
REQ-008 SHALL have port PAT_ERR  output  1  one-cycle pulse on a stable, unrecognised pattern.
REQ-009 SHALL have port ERR_COUNT  output  8  saturating invalid-pattern count; present only with SEG7_ERRCNT_EN.

Function
REQ-010 SHALL register HEX_IN every cycle into hex_q; the stability counter clears when HEX_IN != hex_q and increments (saturating) when equal.
REQ-011 SHALL recognise exactly 16 patterns, 0-F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, active-low).
REQ-012 SHALL implement states SETTLE, HOLD, WAIT_CHANGE; reset state SETTLE.
REQ-013 SETTLE: when HEX_IN is constant from sampling edge k, the decision SHALL occur at edge k+STABLE_CYCLES.
REQ-014 Decision on a recognised pattern SHALL load DIGIT, set DIGIT_VALID, record the pattern as last_pat, go to HOLD.
REQ-015 Decision on 7F (blank) SHALL go to WAIT_CHANGE with no output and no error.
REQ-016 Decision on any other pattern SHALL pulse PAT_ERR for exactly one cycle, record last_pat, go to WAIT_CHANGE.
REQ-017 HOLD: DIGIT and DIGIT_VALID SHALL stay constant until an edge with DIGIT_READY=1; HEX_IN changes during HOLD SHALL be ignored.
REQ-018 Transfer SHALL occur on any edge where DIGIT_VALID and DIGIT_READY are both 1, including the first cycle of VALID; DIGIT_VALID deasserts after that edge.
REQ-019 After transfer SHALL go to WAIT_CHANGE if HEX_IN == last_pat, else SETTLE with the counter cleared.
REQ-020 WAIT_CHANGE: when HEX_IN != last_pat, SHALL go to SETTLE with the counter cleared; an unchanged pattern SHALL never be re-emitted or re-flagged.
REQ-021 DIGIT_READY while DIGIT_VALID=0 SHALL have no effect.

Reset
REQ-022 RESET SHALL asynchronously force: state SETTLE, DIGIT=0, DIGIT_VALID=0, PAT_ERR=0, counter=0, hex_q=7F, last_pat=7F, ERR_COUNT=0.
REQ-023 RESET asserted during HOLD SHALL discard the pending digit; no transfer occurs.

Configuration
REQ-024 With SEG7_ERRCNT_EN defined, ERR_COUNT port SHALL exist, increment on each PAT_ERR pulse, and saturate at 255.
REQ-025 Without SEG7_ERRCNT_EN, the ERR_COUNT port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-026 Package seg7_pkg SHALL hold the 16 pattern constants, BLANK (7F), the state enum, and the counter width.
REQ-027 Sub-module seg7_pattern_match SHALL be combinational: pattern in -> 4-bit value, hit flag, blank flag.

Verification
REQ-028 HEX_IN=24 held, READY=1, STABLE_CYCLES=4 -> DIGIT=2, VALID high exactly one cycle, 4 edges after first sample.
REQ-029 HEX_IN toggles 30/19 every 3 cycles -> no VALID, no PAT_ERR.
REQ-030 HEX_IN=0E held, READY=0 for 10 cycles, then HEX_IN=00 then READY=1 -> DIGIT=F held throughout, one transfer, then DIGIT=8 after 4 more edges.
REQ-031 HEX_IN=55 held 20 cycles -> single PAT_ERR pulse; ERR_COUNT=1 with macro; 300 alternating invalid/blank episodes -> ERR_COUNT=255.
REQ-032 HEX_IN=40 held after transfer for 50 cycles -> no second VALID; blank then 40 -> second DIGIT=0.
REQ-033 RESET pulsed during HOLD -> all outputs 0 immediately, asynchronously, before the next clock edge.
